mem_io_responder: RTL and testbench

Memory-side responder for the CPU's byte-wide memory bus. It serves 128 KB of byte RAM plus the memory-mapped I/O window at 0x30000–0x30007, returning read data one cycle after the address. It buffers UART TX/RX bytes, runs the cycle counter, and raises the program-stop flag. It sits between the CPU's memory interface and the board's UART transmitter/receiver.

---
 rtl/mem_io_pkg.sv | 29 ++
 rtl/byte_fifo.sv | 68 ++++++
 rtl/mem_io_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_io_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/IO responder.
// Holds the address map constants, the region type and the region decoder.
// No ports; imported by mem_io_responder and byte_fifo.
package mem_io_pkg;

  localparam logic [17:0] RAM_TOP = 18'h20000;
  localparam logic [17:0] IO_RXTX = 18'h30000;
  localparam logic [17:0] IO_CNT  = 18'h30004;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_IO   = 2'd1,
    REG_HOLE = 2'd2
  } region_e;

  // Classify an 18-bit byte address into RAM, IO window or unmapped hole.
  function automatic region_e decode_region(input logic [17:0] addr);
    region_e reg_v;
    if (addr < RAM_TOP) begin
      reg_v = REG_RAM;
    end else if (addr[17:16] == 2'b11) begin
      reg_v = REG_IO;
    end else begin
      reg_v = REG_HOLE;
    end
    return reg_v;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO used for the UART TX and RX queues.
// Ports: clk/rst (async active-high), push/din, pop/dout (head, from
// registers), empty/full flags and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle;
// a push into an empty FIFO is not bypassed to dout.
module byte_fifo
  import mem_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty = (count_r == '0);
  assign full  = (count_r == FULL_CNT);
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // Qualify requests against the current occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || pop);
  end

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128 KB RAM, IO window at
// 0x30000-0x30007 (UART TX/RX data, cycle counter snapshot, program stop).
// Ports: clk_in/rst_in (async active-high); cpu_a/cpu_wr/cpu_wdata in,
// cpu_rdata out (1-cycle latency); tx_valid/tx_data/tx_ready to the UART
// transmitter; rx_valid/rx_data from the receiver; io_buffer_full,
// rx_overflow and prog_stop status outputs.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_overflow,
  output logic        prog_stop
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  // One slot of headroom for a write the CPU has already issued.
  localparam logic [TX_CW-1:0] TX_HIGH_LVL = TX_CW'(TX_DEPTH - 1);

  logic [17:0]      addr_s;
  region_e          region_s;
  logic             io_win_s;
  logic [7:0]       ram_r [2**RAM_ADDR_W];
  logic [7:0]       ram_q_r;
  logic             sel_ram_r;
  logic [7:0]       io_q_r;
  logic [7:0]       io_next_s;
  logic [31:0]      cnt_r;
  logic [31:0]      snap_r;
  logic [31:0]      snap_next_s;
  logic             stop_req_r;
  logic             prog_stop_r;
  logic             rx_overflow_r;
  logic             tx_push_s;
  logic [7:0]       tx_din_s;
  logic             tx_pop_s;
  logic             tx_empty_s;
  logic             tx_full_s;
  logic [TX_CW-1:0] tx_count_s;
  logic             stop_wr_s;
  logic             rx_pop_s;
  logic [7:0]       rx_dout_s;
  logic             rx_empty_s;
  logic             rx_full_s;
  logic [RX_CW-1:0] rx_count_s;
  logic             unused_s;

  assign addr_s   = cpu_a[17:0];
  assign region_s = decode_region(addr_s);
  assign io_win_s = (region_s == REG_IO) && (addr_s[15:3] == 13'd0);
  assign tx_pop_s = tx_valid && tx_ready;
  assign unused_s = ^{cpu_a[31:18], tx_full_s, rx_count_s};

  assign cpu_rdata      = sel_ram_r ? ram_q_r : io_q_r;
  assign tx_valid       = !tx_empty_s;
  assign io_buffer_full = (tx_count_s >= TX_HIGH_LVL);
  assign rx_overflow    = rx_overflow_r;
  assign prog_stop      = prog_stop_r;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (tx_push_s),
    .din   (tx_din_s),
    .pop   (tx_pop_s),
    .dout  (tx_data),
    .empty (tx_empty_s),
    .full  (tx_full_s),
    .count (tx_count_s)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop_s),
    .dout  (rx_dout_s),
    .empty (rx_empty_s),
    .full  (rx_full_s),
    .count (rx_count_s)
  );

  // IO write decode: TX pushes, stop request and RX pop on data reads.
  always_comb begin
    tx_push_s = 1'b0;
    tx_din_s  = cpu_wdata;
    stop_wr_s = 1'b0;
    rx_pop_s  = 1'b0;
    if (io_win_s && cpu_wr) begin
      if (addr_s == IO_RXTX) begin
        tx_push_s = (cpu_wdata != 8'h00) && !prog_stop_r;
      end else if (addr_s == IO_CNT) begin
        // Stop marker is a literal 0x00 that bypasses the zero filter.
        tx_push_s = !prog_stop_r;
        tx_din_s  = 8'h00;
        stop_wr_s = 1'b1;
      end else begin
        tx_push_s = 1'b0;
      end
    end else if (io_win_s && !cpu_wr && (addr_s == IO_RXTX)) begin
      rx_pop_s = !rx_empty_s;
    end else begin
      rx_pop_s = 1'b0;
    end
  end

  // IO read mux; offset 4 re-latches the counter snapshot, 5..7 reuse it.
  always_comb begin
    io_next_s   = 8'h00;
    snap_next_s = snap_r;
    if (io_win_s && !cpu_wr) begin
      case (addr_s[2:0])
        3'd0:    io_next_s = rx_empty_s ? 8'h00 : rx_dout_s;
        3'd4: begin
          snap_next_s = cnt_r;
          io_next_s   = cnt_r[7:0];
        end
        3'd5:    io_next_s = snap_r[15:8];
        3'd6:    io_next_s = snap_r[23:16];
        3'd7:    io_next_s = snap_r[31:24];
        default: io_next_s = 8'h00;
      endcase
    end else begin
      io_next_s = 8'h00;
    end
  end

  // RAM array: read-first, so a write cycle returns the old byte. Not reset.
  always_ff @(posedge clk_in) begin
    if ((region_s == REG_RAM) && cpu_wr) begin
      ram_r[addr_s[RAM_ADDR_W-1:0]] <= cpu_wdata;
    end
    ram_q_r <= ram_r[addr_s[RAM_ADDR_W-1:0]];
  end

  // Read-path select, counter, snapshot and sticky status flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_ram_r     <= 1'b0;
      io_q_r        <= 8'h00;
      cnt_r         <= 32'd0;
      snap_r        <= 32'd0;
      stop_req_r    <= 1'b0;
      prog_stop_r   <= 1'b0;
      rx_overflow_r <= 1'b0;
    end else begin
      sel_ram_r     <= (region_s == REG_RAM);
      io_q_r        <= io_next_s;
      snap_r        <= snap_next_s;
      cnt_r         <= prog_stop_r ? cnt_r : cnt_r + 32'd1;
      stop_req_r    <= stop_req_r || stop_wr_s;
      prog_stop_r   <= prog_stop_r || (stop_req_r && tx_empty_s && !tx_pop_s);
      rx_overflow_r <= rx_overflow_r || (rx_valid && rx_full_s && !rx_pop_s);
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  localparam logic [31:0] IDLE_A = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_overflow;
  logic        prog_stop;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;
  sb_t sb_q[$];

  // Reference cycle counter: edges since reset release, frozen on request.
  logic [31:0] tb_cnt;
  bit          frozen = 1'b0;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_overflow    (rx_overflow),
    .prog_stop      (prog_stop)
  );

  always @(posedge clk or posedge rst_in) begin
    if (rst_in) tb_cnt <= 32'd0;
    else if (!frozen) tb_cnt <= tb_cnt + 32'd1;
  end

  // Scoreboard: each expected read byte is due right after the next edge.
  always @(posedge clk) begin
    sb_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total_cnt++;
      if (cpu_rdata !== e.exp) $display("FAIL %s: cpu_rdata=%h expected %h", e.name, cpu_rdata, e.exp);
      else pass_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_rd(input logic [31:0] a, input logic [7:0] exp, input string name);
    cpu_a = a; cpu_wr = 1'b0;
    sb_q.push_back('{exp, name});
    @(negedge clk);
    cpu_a = IDLE_A;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [7:0] d, input bit chk,
                          input logic [7:0] exp, input string name);
    cpu_a = a; cpu_wr = 1'b1; cpu_wdata = d;
    if (chk) sb_q.push_back('{exp, name});
    @(negedge clk);
    cpu_wr = 1'b0; cpu_a = IDLE_A;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; cpu_a = IDLE_A; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    total_cnt++; if (cpu_rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", cpu_rdata); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", tx_data); else pass_cnt++;
    total_cnt++; if (io_buffer_full !== 1'b0) $display("FAIL rst_full: got %b want 0", io_buffer_full); else pass_cnt++;
    total_cnt++; if (rx_overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", rx_overflow); else pass_cnt++;
    total_cnt++; if (prog_stop !== 1'b0) $display("FAIL rst_stop: got %b want 0", prog_stop); else pass_cnt++;
    rst_in = 1'b0;
  endtask

  task automatic test_counter();
    logic [31:0] snap;
    for (int i = 0; i < 1000 && tb_cnt != 32'd500; i++) @(negedge clk);
    total_cnt++; if (tb_cnt != 32'd500) $display("FAIL cnt_wait: reached %0d want 500", tb_cnt); else pass_cnt++;
    snap = tb_cnt;
    drive_rd(32'h30004, snap[7:0], "cnt_b0");
    repeat (3) @(negedge clk);
    drive_rd(32'h30005, snap[15:8], "cnt_b1");
    drive_rd(32'h30006, snap[23:16], "cnt_b2");
    @(negedge clk);
    drive_rd(32'h30007, snap[31:24], "cnt_b3");
    drive_rd(32'h30001, 8'h00, "io_other");
  endtask

  task automatic test_ram();
    drive_wr(32'h01234, 8'h5A, 1'b0, 8'h00, "");
    drive_rd(32'h01234, 8'h5A, "ram_rd_5a");
    drive_wr(32'h01234, 8'h77, 1'b1, 8'h5A, "ram_read_first");
    drive_rd(32'h01234, 8'h77, "ram_rd_77");
    drive_wr(32'h1FFFF, 8'hFF, 1'b0, 8'h00, "");
    drive_rd(32'h1FFFF, 8'hFF, "ram_top");
    drive_wr(32'h20010, 8'h99, 1'b0, 8'h00, "");
    drive_rd(32'h20010, 8'h00, "hole_rd");
  endtask

  task automatic test_tx();
    logic [7:0] exp_tx [8];
    exp_tx = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    tx_ready = 1'b0;
    drive_wr(32'h30000, 8'h41, 1'b1, 8'h00, "io_wr_rdata");
    drive_wr(32'h30000, 8'h00, 1'b0, 8'h00, "");
    drive_wr(32'h30000, 8'h42, 1'b0, 8'h00, "");
    total_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) $display("FAIL tx_head: valid=%b data=%h want 1/41", tx_valid, tx_data); else pass_cnt++;
    for (int i = 0; i < 4; i++) drive_wr(32'h30000, 8'h43 + 8'(i), 1'b0, 8'h00, "");
    total_cnt++; if (io_buffer_full !== 1'b0) $display("FAIL tx_full6: got %b want 0", io_buffer_full); else pass_cnt++;
    drive_wr(32'h30000, 8'h47, 1'b0, 8'h00, "");
    total_cnt++; if (io_buffer_full !== 1'b1) $display("FAIL tx_full7: got %b want 1", io_buffer_full); else pass_cnt++;
    drive_wr(32'h30000, 8'h48, 1'b0, 8'h00, "");
    drive_wr(32'h30000, 8'h49, 1'b0, 8'h00, "");
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== exp_tx[i]) $display("FAIL tx_drain%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, exp_tx[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL tx_empty: got %b want 0 (9th push kept)", tx_valid); else pass_cnt++;
    total_cnt++; if (io_buffer_full !== 1'b0) $display("FAIL tx_full_clr: got %b want 0", io_buffer_full); else pass_cnt++;
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    drive_rd(32'h30000, 8'h00, "rx_empty_rd");
    rx_push(8'h31);
    rx_push(8'h32);
    drive_rd(32'h30000, 8'h31, "rx_rd_31");
    drive_rd(32'h30000, 8'h32, "rx_rd_32");
    drive_rd(32'h30000, 8'h00, "rx_rd_empty2");
    for (int i = 0; i < 8; i++) rx_push(8'h50 + 8'(i));
    total_cnt++; if (rx_overflow !== 1'b0) $display("FAIL rx_ovf8: got %b want 0", rx_overflow); else pass_cnt++;
    rx_push(8'h58);
    total_cnt++; if (rx_overflow !== 1'b1) $display("FAIL rx_ovf9: got %b want 1", rx_overflow); else pass_cnt++;
    for (int i = 0; i < 8; i++) drive_rd(32'h30000, 8'h50 + 8'(i), "rx_ovf_rd");
    drive_rd(32'h30000, 8'h00, "rx_after_ovf");
  endtask

  task automatic test_reset_mid();
    logic [31:0] snap;
    drive_wr(32'h00100, 8'hC3, 1'b0, 8'h00, "");
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) drive_wr(32'h30000, 8'h11 + 8'(i), 1'b0, 8'h00, "");
    total_cnt++; if (io_buffer_full !== 1'b1 || tx_valid !== 1'b1) $display("FAIL pre_rst: full=%b valid=%b want 1/1", io_buffer_full, tx_valid); else pass_cnt++;
    drive_rd(32'h00100, 8'hC3, "pre_rst_ram");
    cpu_a = 32'h00100;
    #2 rst_in = 1'b1;
    #1;
    total_cnt++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL mid_rst_tx: valid=%b data=%h want 0/00", tx_valid, tx_data); else pass_cnt++;
    total_cnt++; if (io_buffer_full !== 1'b0) $display("FAIL mid_rst_full: got %b want 0", io_buffer_full); else pass_cnt++;
    total_cnt++; if (prog_stop !== 1'b0 || rx_overflow !== 1'b0) $display("FAIL mid_rst_flags: stop=%b ovf=%b want 0/0", prog_stop, rx_overflow); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (cpu_rdata !== 8'h00) $display("FAIL mid_rst_rdata: got %h want 00", cpu_rdata); else pass_cnt++;
    @(negedge clk);
    rst_in = 1'b0;
    snap = tb_cnt;
    drive_rd(32'h30004, snap[7:0], "rst_cnt_b0");
    drive_rd(32'h30005, snap[15:8], "rst_cnt_b1");
    drive_rd(32'h00100, 8'hC3, "ram_kept");
  endtask

  task automatic test_stop();
    logic [7:0]  exp_seq [3];
    logic [31:0] snap;
    exp_seq = '{8'h61, 8'h62, 8'h00};
    tx_ready = 1'b0;
    drive_wr(32'h30000, 8'h61, 1'b0, 8'h00, "");
    drive_wr(32'h30000, 8'h62, 1'b0, 8'h00, "");
    drive_wr(32'h30004, 8'h55, 1'b1, 8'h00, "stop_wr_rdata");
    total_cnt++; if (prog_stop !== 1'b0) $display("FAIL stop_early: got %b want 0", prog_stop); else pass_cnt++;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) $display("FAIL stop_seq%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, exp_seq[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (tx_valid !== 1'b0 || prog_stop !== 1'b0) $display("FAIL stop_last_pop: valid=%b stop=%b want 0/0", tx_valid, prog_stop); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (prog_stop !== 1'b1) $display("FAIL stop_rise: got %b want 1", prog_stop); else pass_cnt++;
    frozen = 1'b1;
    tx_ready = 1'b0;
    drive_wr(32'h30000, 8'h70, 1'b0, 8'h00, "");
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL stop_push_ign: got %b want 0", tx_valid); else pass_cnt++;
    repeat (10) @(negedge clk);
    snap = tb_cnt;
    drive_rd(32'h30004, snap[7:0], "frz_b0");
    drive_rd(32'h30005, snap[15:8], "frz_b1");
    drive_rd(32'h30006, snap[23:16], "frz_b2");
    drive_rd(32'h30007, snap[31:24], "frz_b3");
    drive_wr(32'h00200, 8'hAB, 1'b0, 8'h00, "");
    drive_rd(32'h00200, 8'hAB, "ram_after_stop");
    total_cnt++; if (prog_stop !== 1'b1) $display("FAIL stop_sticky: got %b want 1", prog_stop); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_counter();
    test_ram();
    test_tx();
    test_rx();
    test_reset_mid();
    test_stop();
    repeat (2) @(negedge clk);
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: %0d reads never checked", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
